// File: rtl/mac_rr_arbiter.sv
// Round-robin front end that shares one pipelined MAC among num_req_p requesters.
// A tag FIFO records issue order so each in-order MAC result is routed back to its issuer.

module mac_rr_lane #(
  parameter int idx_p   = 0,
  parameter int iw_p    = 2,
  parameter int width_p = 12
) (
  input  logic [iw_p-1:0]    grant,
  input  logic               issue_ok,
  input  logic [iw_p-1:0]    owner,
  input  logic               rsp_ok,
  input  logic [width_p-1:0] a,
  input  logic [width_p-1:0] b,
  output logic               ready,
  output logic               rsp_valid,
  output logic [width_p-1:0] a_sel,
  output logic [width_p-1:0] b_sel
);
  localparam logic [iw_p-1:0] ID = iw_p'(idx_p);

  logic hit;

  assign hit       = (grant == ID);
  assign ready     = hit & issue_ok;
  assign rsp_valid = (owner == ID) & rsp_ok;
  // Zero when not granted so the top can OR-reduce lanes into the operand mux.
  assign a_sel     = hit ? a : '0;
  assign b_sel     = hit ? b : '0;
endmodule

module mac_rr_arbiter #(
  parameter int num_req_p   = 4,
  parameter int width_p     = 12,
  parameter int out_width_p = 32,
  parameter int depth_p     = 4
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [num_req_p-1:0]           req_valid_i,
  input  logic [num_req_p*width_p-1:0]   req_a_i,
  input  logic [num_req_p*width_p-1:0]   req_b_i,
  output logic [num_req_p-1:0]           req_ready_o,
  output logic                           mac_valid_o,
  output logic [width_p-1:0]             mac_a_o,
  output logic [width_p-1:0]             mac_b_o,
  input  logic                           mac_ready_i,
  input  logic                           mac_valid_i,
  input  logic [out_width_p-1:0]         mac_data_i,
  output logic                           mac_ready_o,
  output logic [num_req_p-1:0]           rsp_valid_o,
  output logic [out_width_p-1:0]         rsp_data_o,
  input  logic [num_req_p-1:0]           rsp_ready_i,
  output logic                           err_o
);
  localparam int IW = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int PW = (depth_p > 1) ? $clog2(depth_p) : 1;
  localparam int CW = $clog2(depth_p + 1);

  logic [IW-1:0] ptr, lock_idx, grant, scan_idx, owner;
  logic          lock, scan_hit, full, empty, any_vld, issue_ok, push, pop, rsp_ok, err_q;
  logic [depth_p-1:0][IW-1:0] tags;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic [num_req_p-1:0][width_p-1:0] a_lane, b_lane, a_sel, b_sel;
  logic [num_req_p-1:0]              rdy_lane, rsp_lane;

  function automatic logic [IW-1:0] rr_add(input logic [IW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= num_req_p) s = s - num_req_p;
    return IW'(s);
  endfunction

  function automatic logic [PW-1:0] fifo_inc(input logic [PW-1:0] p);
    return (p == PW'(depth_p - 1)) ? '0 : p + 1'b1;
  endfunction

  assign a_lane = req_a_i;
  assign b_lane = req_b_i;

  // First valid requester at or after ptr, with wrap.
  always_comb begin
    scan_idx = ptr;
    scan_hit = 1'b0;
    for (int k = 0; k < num_req_p; k++) begin
      if (!scan_hit && req_valid_i[rr_add(ptr, k)]) begin
        scan_idx = rr_add(ptr, k);
        scan_hit = 1'b1;
      end
    end
  end

  assign full     = (count == CW'(depth_p));
  assign empty    = (count == '0);
  assign any_vld  = (|req_valid_i) & ~reset_i;
  assign grant    = lock ? lock_idx : scan_idx;
  assign mac_valid_o = any_vld & ~full;
  assign issue_ok = mac_ready_i & ~full & ~reset_i;
  assign push     = mac_valid_o & mac_ready_i;

  assign owner       = tags[rd_ptr];
  assign rsp_ok      = mac_valid_i & ~empty & ~reset_i;
  // With nothing outstanding any arriving result is swallowed and flagged.
  assign mac_ready_o = ~reset_i & (empty | rsp_ready_i[owner]);
  assign pop         = rsp_ok & rsp_ready_i[owner];
  assign rsp_data_o  = mac_data_i;
  assign err_o       = err_q;

  for (genvar i = 0; i < num_req_p; i++) begin : g_lane
    mac_rr_lane #(
      .idx_p   (i),
      .iw_p    (IW),
      .width_p (width_p)
    ) u_lane (
      .grant     (grant),
      .issue_ok  (issue_ok),
      .owner     (owner),
      .rsp_ok    (rsp_ok),
      .a         (a_lane[i]),
      .b         (b_lane[i]),
      .ready     (rdy_lane[i]),
      .rsp_valid (rsp_lane[i]),
      .a_sel     (a_sel[i]),
      .b_sel     (b_sel[i])
    );
  end

  assign req_ready_o = rdy_lane;
  assign rsp_valid_o = rsp_lane;

  always_comb begin
    mac_a_o = '0;
    mac_b_o = '0;
    for (int i = 0; i < num_req_p; i++) begin
      mac_a_o = mac_a_o | a_sel[i];
      mac_b_o = mac_b_o | b_sel[i];
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ptr      <= '0;
      lock     <= 1'b0;
      lock_idx <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      err_q    <= 1'b0;
    end else begin
      if (push) begin
        ptr  <= rr_add(grant, 1);
        lock <= 1'b0;
      end else if (mac_valid_o && !mac_ready_i) begin
        lock     <= 1'b1;
        lock_idx <= grant;
      end
      if (push) wr_ptr <= fifo_inc(wr_ptr);
      if (pop)  rd_ptr <= fifo_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (mac_valid_i && empty) err_q <= 1'b1;
    end
  end

  // Tag storage carries no reset; occupancy is tracked by count.
  always_ff @(posedge clk_i) begin
    if (push) tags[wr_ptr] <= grant;
  end
endmodule

// File: tb/tb_mac_rr_arbiter.sv
// Bench for mac_rr_arbiter: directed scenarios plus random traffic against a queue-based
// model of grant order, outstanding tags and an in-order latency-2 MAC.

module tb_mac_rr_arbiter;
  localparam int N = 4, W = 12, OW = 32, D = 4, LAT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*W-1:0] req_a, req_b;
  logic          mac_valid_o, mac_ready_i, mac_valid_i, mac_ready_o, err;
  logic [W-1:0]  mac_a, mac_b;
  logic [OW-1:0] mac_data, rsp_data;

  always #5 clk = ~clk;

  mac_rr_arbiter #(.num_req_p(N), .width_p(W), .out_width_p(OW), .depth_p(D)) dut (
    .clk_i(clk), .reset_i(rst),
    .req_valid_i(req_valid), .req_a_i(req_a), .req_b_i(req_b), .req_ready_o(req_ready),
    .mac_valid_o(mac_valid_o), .mac_a_o(mac_a), .mac_b_o(mac_b), .mac_ready_i(mac_ready_i),
    .mac_valid_i(mac_valid_i), .mac_data_i(mac_data), .mac_ready_o(mac_ready_o),
    .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_ready_i(rsp_ready),
    .err_o(err)
  );

  typedef struct { int owner; logic [OW-1:0] prod; } tag_t;
  typedef struct { logic [OW-1:0] d; int t; } res_t;

  tag_t tagq[$];
  res_t macq[$];
  int   ptr, lock_idx, cyc;
  bit   locked, m_err, refill;
  bit   sv[N];
  logic [W-1:0] sa[N], sb[N];
  bit   s_mrdy, inj_v;
  logic [N-1:0]  s_rrdy;
  logic [OW-1:0] inj_d;
  int   n_cmp, n_mis;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [OW-1:0] mul(input logic [W-1:0] a, input logic [W-1:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return OW'(p);
  endfunction

  // One clock: apply staged inputs, predict every output, then advance the model.
  task automatic step();
    int g, j, own;
    bit any, full, exp_mv, mv_in, exp_mr, from_q;
    logic [OW-1:0] md, prod;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      req_valid[i] = sv[i];
      req_a[i*W +: W] = sa[i];
      req_b[i*W +: W] = sb[i];
    end
    mac_ready_i = s_mrdy;
    rsp_ready   = s_rrdy;
    from_q = (macq.size() > 0) && (macq[0].t <= cyc);
    mv_in  = from_q || inj_v;
    md     = from_q ? macq[0].d : inj_d;
    mac_valid_i = mv_in;
    mac_data    = md;
    #1;
    any = 0;
    for (int i = 0; i < N; i++) any |= sv[i];
    full = (tagq.size() >= D);
    g = -1;
    if (locked) g = lock_idx;
    else for (int k = 0; k < N; k++) begin
      j = (ptr + k) % N;
      if (g < 0 && sv[j]) g = j;
    end
    exp_mv = any && !full;
    check("mac_valid_o", mac_valid_o, exp_mv);
    if (any) begin
      exp_rdy = '0;
      if (!full && s_mrdy) exp_rdy[g] = 1'b1;
      check("req_ready_o", req_ready, exp_rdy);
      if (!full) begin
        check("mac_a_o", mac_a, sa[g]);
        check("mac_b_o", mac_b, sb[g]);
      end
    end
    if (tagq.size() > 0) begin
      own    = tagq[0].owner;
      exp_mr = s_rrdy[own];
      check("rsp_valid_o", rsp_valid, mv_in ? (64'(1) << own) : 64'(0));
      check("mac_ready_o", mac_ready_o, exp_mr);
      if (mv_in) check("rsp_data_o", rsp_data, md);
    end else begin
      exp_mr = 1;
      check("rsp_valid_o idle", rsp_valid, 0);
      if (mv_in) check("mac_ready_o drop", mac_ready_o, 1);
    end
    check("err_o", err, m_err);

    if (mv_in && tagq.size() == 0) m_err = 1;
    if (mv_in && exp_mr) begin
      if (from_q) void'(macq.pop_front());
      else inj_v = 0;
      if (tagq.size() > 0) void'(tagq.pop_front());
    end
    if (exp_mv && s_mrdy) begin
      prod = mul(sa[g], sb[g]);
      tagq.push_back('{owner: g, prod: prod});
      macq.push_back('{d: prod, t: cyc + LAT});
      ptr    = (g + 1) % N;
      locked = 0;
      sv[g]  = refill;
      if (refill) begin
        sa[g] = W'($urandom);
        sb[g] = W'($urandom);
      end
    end else if (exp_mv) begin
      locked   = 1;
      lock_idx = g;
    end
    cyc++;
  endtask

  task automatic drain();
    for (int i = 0; i < N; i++) sv[i] = 0;
    refill = 0; inj_v = 0; s_rrdy = '1;
    repeat (8) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " mac_valid_o"}, mac_valid_o, 0);
    check({tag, " req_ready_o"}, req_ready, 0);
    check({tag, " mac_ready_o"}, mac_ready_o, 0);
    check({tag, " rsp_valid_o"}, rsp_valid, 0);
    check({tag, " err_o"}, err, 0);
  endtask

  // Async reset away from any edge; outputs must collapse before the next clock.
  task automatic reset_mid();
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("mid reset");
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("held reset");
    tagq.delete(); macq.delete();
    ptr = 0; locked = 0; m_err = 0; inj_v = 0;
    for (int i = 0; i < N; i++) sv[i] = 0;
    req_valid = '0; mac_valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_mis = 0; cyc = 0;
    ptr = 0; locked = 0; lock_idx = 0; m_err = 0; refill = 0; inj_v = 0; inj_d = '0;
    s_mrdy = 0; s_rrdy = '0;
    for (int i = 0; i < N; i++) begin sv[i] = 0; sa[i] = '0; sb[i] = '0; end
    req_valid = '0; req_a = '0; req_b = '0; mac_ready_i = 0; mac_valid_i = 0;
    mac_data = '0; rsp_ready = '0;
    rst = 1'b1;
    #1 check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // All requesters busy, MAC always ready: strict rotation, products routed home.
    for (int i = 0; i < N; i++) begin sv[i] = 1; sa[i] = 12'h100; sb[i] = 12'h080; end
    refill = 1; s_mrdy = 1; s_rrdy = '1;
    repeat (12) step();
    drain();

    // Stall holds the grant on req 2 even after req 0 appears.
    sv[2] = 1; sa[2] = 12'h7ff; sb[2] = 12'h801; s_mrdy = 0;
    step();
    sv[0] = 1; sa[0] = 12'h123; sb[0] = 12'hfff;
    step(); step();
    s_mrdy = 1;
    repeat (3) step();
    drain();

    // Results blocked: issue stops at depth, then resumes as the FIFO drains.
    for (int i = 0; i < N; i++) sv[i] = 1;
    refill = 1; s_mrdy = 1; s_rrdy = '0;
    repeat (7) step();
    s_rrdy = '1;
    repeat (8) step();
    drain();

    // Two in flight, then issue and retire together every cycle.
    for (int i = 0; i < N; i++) sv[i] = 1;
    refill = 1; s_mrdy = 1; s_rrdy = '0;
    repeat (2) step();
    s_rrdy = '1;
    repeat (6) step();
    drain();

    // Result with nothing outstanding: dropped and err_o sticks.
    inj_v = 1; inj_d = 32'hdead_beef;
    repeat (4) step();

    // Random traffic with requesters that hold until accepted.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) if (!sv[i] && ($urandom % 2) == 1) begin
        sv[i] = 1; sa[i] = W'($urandom); sb[i] = W'($urandom);
      end
      s_mrdy = ($urandom % 4) != 0;
      s_rrdy = N'($urandom);
      step();
    end
    drain();

    // Reset with three tags outstanding, then only req 3 asks.
    for (int i = 0; i < N; i++) sv[i] = 1;
    refill = 1; s_mrdy = 1; s_rrdy = '0;
    repeat (3) step();
    reset_mid();
    refill = 0; s_rrdy = '1;
    sv[3] = 1; sa[3] = 12'h0a5; sb[3] = 12'hf5a;
    repeat (4) step();
    drain();

    // A stale result after reset is flagged.
    reset_mid();
    inj_v = 1; inj_d = 32'h1234_5678;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
